// File: rtl/wb_master_pkg.sv
// Shared types and default constants for the Wishbone command master.
// Imported by wb_cmd_master and wbm_timeout_ctr.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;

    localparam int unsigned WBM_ADDR_W          = 32;
    localparam int unsigned WBM_DATA_W          = 32;
    localparam int unsigned WBM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Bus-cycle watchdog: counts cycles spent waiting for a slave reply.
// Only instantiated when WB_TIMEOUT_EN is defined.
module wbm_timeout_ctr
    import wb_master_pkg::*;
#(
    parameter int unsigned LIMIT = WBM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] cnt;

    // Restart on entry to a bus cycle, then count each waiting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Flags the last permitted waiting cycle so the FSM aborts on its edge.
    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator bridging a valid/ready command stream to single
// read/write cycles. Optional ack watchdog enabled by defining WB_TIMEOUT_EN.
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = WBM_ADDR_W,
    parameter int unsigned DATA_W         = WBM_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = WBM_TIMEOUT_DEFAULT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [DATA_W/8-1:0] cmd_sel_i,
    input  logic [ADDR_W-1:0]   cmd_adr_i,
    input  logic [DATA_W-1:0]   cmd_dat_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i,
    input  logic [DATA_W-1:0]   wbm_dat_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT_CYCLES out of range 1..65535");
    end

    wbm_state_t state;
    logic       cmd_hs;

    assign cmd_hs = (state == IDLE) && cmd_valid_i && cmd_ready_o;

`ifdef WB_TIMEOUT_EN
    logic expired;

    wbm_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .clear  (cmd_hs),
        .enable (state == BUS),
        .expired(expired)
    );
`endif

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        cmd_ready_o <= 1'b0;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        wbm_we_o    <= cmd_we_i;
                        wbm_sel_o   <= cmd_sel_i;
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_dat_o   <= cmd_dat_i;
                        state       <= BUS;
                    end else begin
                        cmd_ready_o <= 1'b1;
                    end
                end
                BUS: begin
                    if (wbm_err_i) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_dat_o   <= '0;
                        state       <= RESP;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
                        state       <= RESP;
`ifdef WB_TIMEOUT_EN
                    end else if (expired) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_dat_o   <= '0;
                        state       <= RESP;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    wbm_cyc_o   <= 1'b0;
                    wbm_stb_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master; timeout cases run when WB_TIMEOUT_EN
// is defined, otherwise an indefinite-wait case runs instead.
module tb_wb_cmd_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        ack;
    logic        err;
    logic [31:0] rdat;

    int n_chk  = 0;
    int n_pass = 0;
    int cnt;

    wb_cmd_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_sel_i  (cmd_sel),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (wdat),
        .wbm_ack_i  (ack),
        .wbm_err_i  (err),
        .wbm_dat_i  (rdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one handshake edge.
    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait on cyc with a bounded budget, acking on BUS cycle ack_at (0 = never).
    task automatic run_bus(input int ack_at, input logic [31:0] d,
                           output int n);
        n = 0;
        for (int i = 0; i < 40 && cyc; i++) begin
            n++;
            if (n == ack_at) begin
                ack  = 1'b1;
                rdat = d;
            end
            tick();
            ack = 1'b0;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0;
        cmd_adr = '0; cmd_dat = '0; rsp_ready = 1'b0;
        ack = 1'b0; err = 1'b0; rdat = '0;

        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_cyc_stb", {cyc, stb, we}, 0);
        chk("rst_adr_dat", {adr, wdat}, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", cmd_ready, 1);

        // Write with zero-wait ack.
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        chk("wr_cyc_stb", {cyc, stb}, 2'b11);
        chk("wr_we", we, 1);
        chk("wr_adr", adr, 32'h3000_0004);
        chk("wr_dat", wdat, 32'hDEAD_BEEF);
        chk("wr_sel", sel, 4'hF);
        chk("wr_busy", cmd_ready, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_cyc_low", cyc, 0);
        chk("wr_rsp", {rsp_err, rsp_dat}, 33'h0);
        take_rsp();
        chk("wr_done", {rsp_valid, cmd_ready}, 2'b01);

        // Read with 3 wait cycles, then a stalled response consumer.
        issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        chk("rd_we", we, 0);
        run_bus(4, 32'h1234_5678, cnt);
        chk("rd_cyc_len", cnt, 4);
        chk("rd_rsp", {rsp_valid, rsp_err, rsp_dat}, {2'b10, 32'h1234_5678});
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0008;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_rsp", {rsp_valid, rsp_dat}, {1'b1, 32'h1234_5678});
            chk("stall_ready", {cmd_ready, cyc}, 2'b00);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("stall_release", {rsp_valid, cmd_ready}, 2'b01);

        // Pending command handshakes now; slave returns ack and err together.
        tick();
        cmd_valid = 1'b0;
        chk("ae_cyc", cyc, 1);
        chk("ae_adr", adr, 32'h3000_0008);
        ack = 1'b1; err = 1'b1; rdat = 32'hFFFF_FFFF;
        tick();
        ack = 1'b0; err = 1'b0;
        chk("ae_rsp", {rsp_valid, rsp_err, rsp_dat}, {2'b11, 32'h0});
        chk("ae_cyc_low", cyc, 0);
        take_rsp();

        // Unsolicited ack and err in IDLE are ignored.
        ack = 1'b1; err = 1'b1;
        tick();
        ack = 1'b0; err = 1'b0;
        chk("unsol", {rsp_valid, cyc, cmd_ready}, 3'b001);

`ifdef WB_TIMEOUT_EN
        issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        run_bus(0, 32'h0, cnt);
        chk("tmo_len", cnt, 8);
        chk("tmo_rsp", {rsp_valid, rsp_err, rsp_dat}, {2'b11, 32'h0});
        take_rsp();
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        run_bus(8, 32'hA5A5_5A5A, cnt);
        chk("tmo_ack_len", cnt, 8);
        chk("tmo_ack_rsp", {rsp_valid, rsp_err, rsp_dat},
            {2'b10, 32'hA5A5_5A5A});
        take_rsp();
`else
        issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        run_bus(20, 32'h0BAD_CAFE, cnt);
        chk("wait_len", cnt, 20);
        chk("wait_rsp", {rsp_valid, rsp_err, rsp_dat},
            {2'b10, 32'h0BAD_CAFE});
        take_rsp();
`endif

        // Asynchronous reset in the middle of a bus cycle.
        issue(1'b1, 32'h3000_0020, 32'h5555_AAAA, 4'h3);
        chk("mid_cyc", cyc, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async", {cyc, stb}, 2'b00);
        chk("mid_rsp", rsp_valid, 0);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("mid_rsp_held", {rsp_valid, cmd_ready}, 2'b00);
        rst_n = 1'b1;
        tick();
        chk("mid_ready", cmd_ready, 1);
        issue(1'b1, 32'h3000_0024, 32'h0102_0304, 4'hC);
        chk("after_adr", {adr, wdat}, {32'h3000_0024, 32'h0102_0304});
        chk("after_sel", sel, 4'hC);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("after_rsp", {rsp_valid, rsp_err, rsp_dat}, {2'b10, 32'h0});
        take_rsp();
        chk("after_idle", cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
